// File: rtl/morse_pkg.sv
// Shared FSM state type and Morse timing ratios for the straight-key decoder.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_GAP,
        ST_WORD
    } morse_state_t;

    localparam int unsigned DASH_UNITS       = 2;
    localparam int unsigned LETTER_GAP_UNITS = 3;
    localparam int unsigned WORD_GAP_UNITS   = 7;
    localparam int unsigned MAX_ELEMENTS     = 5;

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer followed by a stable-count debouncer for the raw key contact.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic key_db
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] stable_cnt;

    // key_db follows sync2 once it has disagreed for DEBOUNCE_CYCLES edges in a row
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            key_db     <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            if (sync2 == key_db) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                key_db     <= sync2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/morse_key_decoder.sv
// Straight-key Morse decoder: classifies debounced marks and gaps into
// Dot/Dash/EndSeq/Space pulses, with Error when a letter overflows.
module morse_key_decoder
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES     = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Key,
    output logic Dot,
    output logic Dash,
    output logic EndSeq,
    output logic Space,
    output logic Error
);

    localparam int unsigned DASH_LEN   = DASH_UNITS * UNIT_CYCLES;
    localparam int unsigned LETTER_GAP = LETTER_GAP_UNITS * UNIT_CYCLES;
    localparam int unsigned WORD_GAP   = WORD_GAP_UNITS * UNIT_CYCLES;
    localparam int unsigned MW = $clog2(DASH_LEN + 1);
    localparam int unsigned GW = $clog2(WORD_GAP + 1);
    localparam int unsigned EW = $clog2(MAX_ELEMENTS + 1);

    localparam logic [MW-1:0] MARK_SAT   = MW'(DASH_LEN);
    localparam logic [GW-1:0] GAP_LETTER = GW'(LETTER_GAP);
    localparam logic [GW-1:0] GAP_WORD   = GW'(WORD_GAP);
    localparam logic [EW-1:0] ELEM_FULL  = EW'(MAX_ELEMENTS);

    logic          key_db;
    morse_state_t  state, state_nx;
    logic [MW-1:0] mark_cnt, mark_nx;
    logic [GW-1:0] gap_cnt, gap_nx;
    logic [EW-1:0] elem_cnt, elem_nx;
    logic          dot_nx, dash_nx, endseq_nx, space_nx, error_nx;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (Clk),
        .reset (Reset),
        .key   (Key),
        .key_db(key_db)
    );

    // gap_cnt holds the count for the current cycle; the release cycle is 1, so it loads 2
    always_comb begin
        state_nx  = state;
        mark_nx   = mark_cnt;
        gap_nx    = gap_cnt;
        elem_nx   = elem_cnt;
        dot_nx    = 1'b0;
        dash_nx   = 1'b0;
        endseq_nx = 1'b0;
        space_nx  = 1'b0;
        error_nx  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                gap_nx = '0;
                if (key_db) begin
                    state_nx = ST_MARK;
                    mark_nx  = MW'(1);
                end
            end
            ST_MARK: begin
                if (key_db) begin
                    if (mark_cnt != MARK_SAT) mark_nx = mark_cnt + 1'b1;
                end else begin
                    state_nx = ST_GAP;
                    gap_nx   = GW'(2);
                    if (elem_cnt == ELEM_FULL) begin
                        error_nx = 1'b1;
                    end else begin
                        elem_nx = elem_cnt + 1'b1;
                        if (mark_cnt < MARK_SAT) dot_nx  = 1'b1;
                        else                     dash_nx = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (key_db) begin
                    state_nx = ST_MARK;
                    mark_nx  = MW'(1);
                end else if (gap_cnt == GAP_LETTER) begin
                    endseq_nx = 1'b1;
                    elem_nx   = '0;
                    state_nx  = ST_WORD;
                    gap_nx    = gap_cnt + 1'b1;
                end else begin
                    gap_nx = gap_cnt + 1'b1;
                end
            end
            ST_WORD: begin
                if (key_db) begin
                    state_nx = ST_MARK;
                    mark_nx  = MW'(1);
                end else if (gap_cnt == GAP_WORD) begin
                    space_nx = 1'b1;
                    state_nx = ST_IDLE;
                    gap_nx   = '0;
                end else begin
                    gap_nx = gap_cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            mark_cnt <= '0;
            gap_cnt  <= '0;
            elem_cnt <= '0;
            Dot      <= 1'b0;
            Dash     <= 1'b0;
            EndSeq   <= 1'b0;
            Space    <= 1'b0;
            Error    <= 1'b0;
        end else begin
            state    <= state_nx;
            mark_cnt <= mark_nx;
            gap_cnt  <= gap_nx;
            elem_cnt <= elem_nx;
            Dot      <= dot_nx;
            Dash     <= dash_nx;
            EndSeq   <= endseq_nx;
            Space    <= space_nx;
            Error    <= error_nx;
        end
    end

endmodule

// File: tb/tb_morse_key_decoder.sv
// Scoreboard bench for morse_key_decoder with UNIT_CYCLES=4, DEBOUNCE_CYCLES=2.
module tb_morse_key_decoder;
    import morse_pkg::*;

    localparam int C_DOT = 0, C_DASH = 1, C_END = 2, C_SPACE = 3, C_ERR = 4;

    logic Clk = 1'b0;
    logic Reset, Key;
    logic Dot, Dash, EndSeq, Space, Error;

    typedef struct {
        int code;
        int delta;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_pulse = 0;
    int   lat;
    int   glitch_hi;

    morse_key_decoder #(
        .UNIT_CYCLES(4),
        .DEBOUNCE_CYCLES(2)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Key(Key),
        .Dot(Dot), .Dash(Dash), .EndSeq(EndSeq), .Space(Space), .Error(Error)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1);
    end

    // Monitor: every output pulse pops one expected event; delta >= 0 also checks spacing
    always @(negedge Clk) begin
        logic [4:0] seen, want;
        exp_t e;
        seen = {Error, Space, EndSeq, Dash, Dot};
        if (!Reset && seen != 5'b0) begin
            total++;
            if ($countones(seen) != 1) begin
                bad++;
                $display("FAIL onehot: outputs=%b required exactly one bit", seen);
            end else if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: outputs=%b required none", seen);
            end else begin
                e = sbq.pop_front();
                want = 5'b1 << e.code;
                if (seen != want) begin
                    bad++;
                    $display("FAIL pulse_kind: got %b required %b", seen, want);
                end else if (e.delta >= 0) begin
                    total++;
                    if (cyc - last_pulse != e.delta) begin
                        bad++;
                        $display("FAIL pulse_spacing: got %0d cycles required %0d",
                                 cyc - last_pulse, e.delta);
                    end
                end
            end
            last_pulse = cyc;
        end
    end

    task automatic expect_ev(input int code, input int delta);
        exp_t e;
        e.code  = code;
        e.delta = delta;
        sbq.push_back(e);
    endtask

    task automatic cmp(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic hold(input logic v, input int n);
        Key = v;
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic check_empty(input string name);
        cmp({name, "_pending"}, sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic check_idle(input string name);
        cmp({name, "_outputs"}, int'({Error, Space, EndSeq, Dash, Dot}), 0);
        cmp({name, "_state"}, int'(dut.state), int'(ST_IDLE));
        cmp({name, "_key_db"}, int'(dut.u_debounce.key_db), 0);
    endtask

    initial begin
        Reset = 1'b1;
        Key   = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_idle("reset");
        Reset = 1'b0;

        // Single dot, latency both ways, then letter and word gap; no second Space
        expect_ev(C_DOT, -1);
        expect_ev(C_END, 11);
        expect_ev(C_SPACE, 16);
        Key = 1'b1;
        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge Clk);
            #1;
            if (lat == 0 && dut.u_debounce.key_db) lat = i;
        end
        cmp("rise_latency", lat, 4);
        Key = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge Clk);
            #1;
            if (lat == 0 && !dut.u_debounce.key_db) lat = i;
        end
        cmp("fall_latency", lat, 4);
        hold(1'b0, 60);
        check_empty("dot_letter");

        // ".-" then long silence
        expect_ev(C_DOT, -1);
        expect_ev(C_DASH, 12);
        expect_ev(C_END, 11);
        expect_ev(C_SPACE, 16);
        hold(1'b1, 4);
        hold(1'b0, 4);
        hold(1'b1, 8);
        hold(1'b0, 60);
        check_empty("dot_dash");

        // Key rises on the letter-gap threshold cycle: same letter continues to overflow
        expect_ev(C_DOT, -1);
        expect_ev(C_DOT, 15);
        for (int i = 0; i < 3; i++) expect_ev(C_DOT, 8);
        expect_ev(C_ERR, 8);
        expect_ev(C_END, 11);
        expect_ev(C_SPACE, 16);
        hold(1'b1, 4);
        hold(1'b0, 11);
        hold(1'b1, 4);
        for (int i = 0; i < 4; i++) begin
            hold(1'b0, 4);
            hold(1'b1, 4);
        end
        hold(1'b0, 60);
        check_empty("threshold_race");

        // Six short marks in one letter
        expect_ev(C_DOT, -1);
        for (int i = 0; i < 4; i++) expect_ev(C_DOT, 8);
        expect_ev(C_ERR, 8);
        expect_ev(C_END, 11);
        expect_ev(C_SPACE, 16);
        for (int i = 0; i < 6; i++) begin
            hold(1'b1, 4);
            hold(1'b0, (i == 5) ? 60 : 4);
        end
        check_empty("six_marks");

        // One-cycle raw glitch
        glitch_hi = 0;
        Key = 1'b1;
        @(posedge Clk);
        #1;
        Key = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            #1;
            if (dut.u_debounce.key_db) glitch_hi = 1;
        end
        cmp("glitch_key_db", glitch_hi, 0);
        hold(1'b0, 30);
        check_empty("glitch");

        // Reset mid-mark aborts the symbol
        hold(1'b1, 10);
        Reset = 1'b1;
        Key   = 1'b0;
        @(posedge Clk);
        #1;
        check_idle("mid_mark_reset");
        Reset = 1'b0;
        hold(1'b0, 60);
        check_empty("mid_mark_abort");

        // Key held across reset release decodes as a fresh 5-cycle mark
        expect_ev(C_DOT, -1);
        expect_ev(C_END, 11);
        expect_ev(C_SPACE, 16);
        hold(1'b1, 4);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        hold(1'b1, 5);
        hold(1'b0, 60);
        check_empty("held_across_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
